gpio_controller: RTL and testbench

- Memory-mapped GPIO peripheral sitting directly downstream of the memory controller.
- Consumes the controller's GPIO write strobe plus bus write data, drives the board output pins from a register.
- Returns synchronized, debounced input-pin state on the GPIO read-data path, which the controller muxes onto the bus for GPIO_IN_ADDR loads.
- Read path is combinational from registers, so the single-cycle core sees loads with zero wait states.

---
 rtl/mem_pkg.sv | 17 +
 rtl/gpio_debounce_bit.sv | 86 ++++++++
 rtl/gpio_controller.sv | 69 ++++++
 tb/tb_gpio_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-mapped peripherals.
// No logic; parameters and enums only.
// No flow control: constants only.
package mem_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  localparam int GPIO_IN_WIDTH        = 8;
  localparam int GPIO_OUT_WIDTH       = 8;
  localparam int GPIO_DEBOUNCE_CYCLES = 4;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } GPIO_DB_STATE_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: two-flop synchronizer, then a debounce FSM guarding the db flop.
// Latency: pin change sampled at edge k shows on db after edge k+1+DEBOUNCE_CYCLES.
// No backpressure: consumes the pin every cycle.
module gpio_debounce_bit
  import mem_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic db,
  output logic db_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic           s1;
  logic           s2;
  GPIO_DB_STATE_t state;
  GPIO_DB_STATE_t state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;

  // Plain two-flop chain: nothing may sit between the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // FSM state, settle counter and debounced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DB_STABLE;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      db    <= db_next;
    end
  end

  // Next state: a pin must disagree with db for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    db_next    = db;
    case (state)
      DB_STABLE: begin
        if (s2 != db) begin
          if (DEBOUNCE_CYCLES == 1) begin
            db_next = s2;
          end else begin
            cnt_next   = CW'(1);
            state_next = DB_SETTLING;
          end
        end
      end
      DB_SETTLING: begin
        if (s2 == db) begin
          // Glitch: the pin went back before the window completed.
          cnt_next   = '0;
          state_next = DB_STABLE;
        end else if (cnt == CNT_LAST) begin
          db_next    = s2;
          cnt_next   = '0;
          state_next = DB_STABLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = DB_STABLE;
      end
    endcase
  end

endmodule

// File: rtl/gpio_controller.sv
// GPIO peripheral: registered output pins, debounced input pins read combinationally (optional IRQ: GPIO_IRQ_EN).
// Latency: write visible next cycle; input change after 1+DEBOUNCE_CYCLES edges past sampling.
// No backpressure: write strobe always accepted, read path has zero wait states.
module gpio_controller
  import mem_pkg::*;
#(
  parameter int IN_WIDTH        = GPIO_IN_WIDTH,
  parameter int OUT_WIDTH       = GPIO_OUT_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  RV32I_OPERAND_t       bus_wrdata,
  input  logic                 gpio_wren,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out,
  output RV32I_OPERAND_t       gpio_rddata
`ifdef GPIO_IRQ_EN
  ,
  output logic                 gpio_irq
`endif
);

  logic [IN_WIDTH-1:0] db;
  logic [IN_WIDTH-1:0] db_next;

  // Upper store-data bits beyond OUT_WIDTH are intentionally dropped.
  logic unused_wrdata;
  assign unused_wrdata = ^bus_wrdata;

  // Output register: loads on the write strobe, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
    end else if (gpio_wren) begin
      gpio_out <= bus_wrdata[OUT_WIDTH-1:0];
    end
  end

  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_pin
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .pin     (gpio_in[g]),
      .db      (db[g]),
      .db_next (db_next[g])
    );
  end

  // Read data is zero-extended db, independent of the bus address.
  assign gpio_rddata = RV32I_OPERAND_t'(db);

`ifdef GPIO_IRQ_EN
  // One-cycle pulse aligned with the first cycle a changed value is readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_irq <= 1'b0;
    end else begin
      gpio_irq <= |(db_next ^ db);
    end
  end
`else
  logic unused_db_next;
  assign unused_db_next = ^db_next;
`endif

endmodule

// File: tb/tb_gpio_controller.sv
// Self-checking bench for gpio_controller: directed scenarios plus randomized
// traffic compared against a sample-history reference model.
module tb_gpio_controller;

  localparam int IW = 8;
  localparam int OW = 8;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_wrdata = '0;
  logic        gpio_wren = 1'b0;
  logic [IW-1:0] gpio_in = '0;
  logic [OW-1:0] gpio_out;
  logic [31:0] gpio_rddata;
`ifdef GPIO_IRQ_EN
  logic        gpio_irq;
`endif

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gpio_controller #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_wrdata  (bus_wrdata),
    .gpio_wren   (gpio_wren),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_rddata (gpio_rddata)
`ifdef GPIO_IRQ_EN
    ,
    .gpio_irq    (gpio_irq)
`endif
  );

  // Reference model: a pin's debounced value flips once the last DC synchronized
  // samples all disagree with it and DC samples have elapsed since the last flip.
  logic [IW-1:0] m_pipe1 = '0;
  logic [IW-1:0] m_pipe2 = '0;
  logic [IW-1:0] m_db = '0;
  logic [OW-1:0] m_out = '0;
  logic          m_irq = 1'b0;
  logic [IW-1:0] m_hist[$];
  int            m_since[IW];

  always @(posedge clk) begin
    logic [IW-1:0] nxt;
    bit all_diff;
    if (rst) begin
      m_pipe1 = '0;
      m_pipe2 = '0;
      m_db    = '0;
      m_out   = '0;
      m_irq   = 1'b0;
      m_hist.delete();
      for (int i = 0; i < IW; i++) m_since[i] = 0;
    end else begin
      nxt = m_db;
      m_hist.push_back(m_pipe2);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      for (int i = 0; i < IW; i++) begin
        m_since[i]++;
        if (m_since[i] >= DC) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_db[i]) all_diff = 1'b0;
          if (all_diff) begin
            nxt[i] = ~m_db[i];
            m_since[i] = 0;
          end
        end
      end
      m_irq   = (nxt != m_db);
      m_db    = nxt;
      m_pipe2 = m_pipe1;
      m_pipe1 = gpio_in;
      if (gpio_wren) m_out = bus_wrdata[OW-1:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [IW-1:0] v);
    gpio_in = v;
    repeat (2 + 2 * DC) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gpio_in = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (gpio_out !== 8'h00 || gpio_rddata !== 32'h0) begin
        errs++;
        $display("FAIL reset_hold: out=%h rd=%h want 00/00000000", gpio_out, gpio_rddata);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (gpio_rddata !== ((e >= 6) ? 32'hFF : 32'h0)) begin
        errs++;
        $display("FAIL reset_redebounce edge %0d: rd=%h want %h", e, gpio_rddata,
                 (e >= 6) ? 32'hFF : 32'h0);
      end
    end
  endtask

  task automatic test_output();
    gpio_wren = 1'b1;
    bus_wrdata = 32'hDEADBEA5;
    tick();
    gpio_wren = 1'b0;
    bus_wrdata = 32'h12345678;
    vectors++;
    if (gpio_out !== 8'hA5) begin
      errs++;
      $display("FAIL out_write: out=%h want a5", gpio_out);
    end
    repeat (2) tick();
    vectors++;
    if (gpio_out !== 8'hA5) begin
      errs++;
      $display("FAIL out_hold: out=%h want a5", gpio_out);
    end
  endtask

  task automatic test_latency();
    settle(8'h00);
    gpio_in = 8'h01;
    for (int e = 1; e <= 7; e++) begin
      tick();
      vectors++;
      if (gpio_rddata !== ((e >= 6) ? 32'h1 : 32'h0)) begin
        errs++;
        $display("FAIL latency edge %0d: rd=%h want %h", e, gpio_rddata,
                 (e >= 6) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    logic seen;
    settle(8'h00);
    pulses = 0;
    gpio_in = 8'h01;
    repeat (3) tick();
    gpio_in = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
`ifdef GPIO_IRQ_EN
      if (gpio_irq === 1'b1) pulses++;
`endif
      vectors++;
      if (gpio_rddata !== 32'h0) begin
        errs++;
        $display("FAIL glitch_reject cycle %0d: rd=%h want 0", c, gpio_rddata);
      end
    end
`ifdef GPIO_IRQ_EN
    vectors++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL glitch_irq: pulses=%0d want 0", pulses);
    end
`endif
    seen = 1'b0;
    gpio_in = 8'h01;
    repeat (4) tick();
    gpio_in = 8'h00;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (gpio_rddata === 32'h1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b1) begin
      errs++;
      $display("FAIL glitch_accept4: seen=%b want 1", seen);
    end
  endtask

  task automatic test_concurrency();
    settle(8'h00);
    gpio_in = 8'hC3;
    gpio_wren = 1'b1;
    bus_wrdata = 32'h0000003C;
    tick();
    gpio_wren = 1'b0;
    vectors++;
    if (gpio_out !== 8'h3C) begin
      errs++;
      $display("FAIL conc_out: out=%h want 3c", gpio_out);
    end
    for (int e = 2; e <= 7; e++) begin
      tick();
      vectors++;
      if (gpio_rddata !== ((e >= 6) ? 32'hC3 : 32'h0)) begin
        errs++;
        $display("FAIL conc_rd edge %0d: rd=%h want %h", e, gpio_rddata,
                 (e >= 6) ? 32'hC3 : 32'h0);
      end
    end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_irq();
    int pulses;
    logic [31:0] prev;
    settle(8'h00);
    pulses = 0;
    prev = gpio_rddata;
    gpio_in = 8'h81;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gpio_irq === 1'b1) pulses++;
      vectors++;
      if (gpio_irq !== ((gpio_rddata == 32'h81 && prev != 32'h81) ? 1'b1 : 1'b0)) begin
        errs++;
        $display("FAIL irq_align cycle %0d: irq=%b rd=%h prev=%h", c, gpio_irq, gpio_rddata, prev);
      end
      prev = gpio_rddata;
    end
    vectors++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL irq_single: pulses=%0d want 1", pulses);
    end
    gpio_in = 8'h00;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gpio_irq === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL irq_reset_midsettle: pulses=%0d want 0", pulses);
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 2))
          0: gpio_in = IW'($urandom);
          1: gpio_in = gpio_in ^ IW'(1 << $urandom_range(0, IW - 1));
          default: gpio_in = gpio_in;
        endcase
        hold = $urandom_range(1, 2 * DC + 1);
      end
      hold--;
      gpio_wren  = ($urandom_range(0, 3) == 0);
      bus_wrdata = $urandom;
      rst        = ($urandom_range(0, 199) == 0);
      tick();
      vectors++;
      if (gpio_out !== m_out) begin
        errs++;
        $display("FAIL rand_out cycle %0d: out=%h want %h", c, gpio_out, m_out);
      end
      vectors++;
      if (gpio_rddata !== {{(32 - IW){1'b0}}, m_db}) begin
        errs++;
        $display("FAIL rand_rd cycle %0d: rd=%h want %h", c, gpio_rddata, m_db);
      end
`ifdef GPIO_IRQ_EN
      vectors++;
      if (gpio_irq !== m_irq) begin
        errs++;
        $display("FAIL rand_irq cycle %0d: irq=%b want %b", c, gpio_irq, m_irq);
      end
`endif
    end
    rst = 1'b0;
    gpio_wren = 1'b0;
  endtask

  initial begin
    test_reset();
    test_output();
    test_latency();
    test_glitch();
    test_concurrency();
`ifdef GPIO_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
